summer_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit summer adder among NREQ neuron requesters. Each requester presents an operand pair with a valid/grant handshake. The arbiter selects one requester per cycle, forms the 4-bit sum and carry, and returns the result in a registered output slot tagged with the requester index. It sits between the per-neuron product stages and the shared accumulation adder. Output backpressure stalls all grants.

---
 rtl/summer_arbiter_if.sv | 27 ++
 rtl/summer_arbiter.sv | 104 ++++++++++
 tb/tb_summer_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/summer_arbiter_if.sv
// Bus bundle between the neuron requesters/result consumer and the shared summer arbiter.
interface summer_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] a_flat;
  logic [4*NREQ-1:0] b_flat;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_sum;
  logic              out_cout;
  logic [IDW-1:0]    out_id;

  // Requester/consumer side
  modport master (
    output req, a_flat, b_flat, out_ready,
    input  gnt, out_valid, out_sum, out_cout, out_id
  );

  // Arbiter side
  modport slave (
    input  req, a_flat, b_flat, out_ready,
    output gnt, out_valid, out_sum, out_cout, out_id
  );
endinterface

// File: rtl/summer_arbiter.sv
// Round-robin arbiter sharing one 4-bit summer among NREQ requesters, with a
// single registered result slot tagged by requester index.
module summer_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  summer_arbiter_if.slave    bus
);

  localparam int unsigned OPW = 4;

  logic [IDW-1:0]  r_ptr;
  logic            r_out_valid;
  logic [OPW-1:0]  r_out_sum;
  logic            r_out_cout;
  logic [IDW-1:0]  r_out_id;

  logic            w_slot_free;
  logic            w_found;
  logic [IDW-1:0]  w_sel;
  logic [NREQ-1:0] w_gnt;
  logic            w_xfer;
  logic [OPW-1:0]  w_a;
  logic [OPW-1:0]  w_b;
  logic [OPW:0]    w_sum5;
  logic [IDW-1:0]  w_ptr_nxt;

  // Slot can take a new result when empty or being drained this cycle
  assign w_slot_free = !r_out_valid || bus.out_ready;

  // Round-robin scan: first requester at or above ptr, else lowest overall (wrap)
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!w_found && bus.req[i] && (IDW'(i) >= r_ptr)) begin
        w_found = 1'b1;
        w_sel   = IDW'(i);
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!w_found && bus.req[i]) begin
        w_found = 1'b1;
        w_sel   = IDW'(i);
      end
    end
  end

  // One-hot grant, suppressed in reset and while the slot is stalled
  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      w_gnt[i] = rst_n && w_slot_free && w_found && (w_sel == IDW'(i));
    end
  end

  assign w_xfer = |w_gnt;

  // Operand mux driven by the grant; operands reach outputs only via the slot
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_gnt[i]) begin
        w_a = bus.a_flat[4*i +: 4];
        w_b = bus.b_flat[4*i +: 4];
      end
    end
  end

  // Shared summer; the fifth bit is the carry out of bit 3
  assign w_sum5 = {1'b0, w_a} + {1'b0, w_b};

  // Pointer moves just past the winner, wrapping at NREQ-1 for any NREQ
  assign w_ptr_nxt = (w_sel == IDW'(NREQ - 1)) ? '0 : (w_sel + IDW'(1));

  // Result slot and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_id    <= '0;
    end else if (w_xfer) begin
      r_ptr       <= w_ptr_nxt;
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum5[OPW-1:0];
      r_out_cout  <= w_sum5[OPW];
      r_out_id    <= w_sel;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_id    = r_out_id;

endmodule

// File: tb/tb_summer_arbiter.sv
// Scoreboard bench for summer_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_summer_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    int sum;
    int cout;
    int id;
  } res_t;

  logic clk;
  logic rst_n;

  summer_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  summer_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q[$];
  int   m_ptr   = 0;
  bit   m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first pending requester scanning from ptr, wrapping
  function automatic int pick(input logic [NREQ-1:0] rq, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (((rq >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  // Compare the registered slot against the model's current slot contents
  task automatic check_state();
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("slot_model_empty", 0, 1);
      end else begin
        chk("slot_sum",  int'(bus.out_sum),  exp_q[0].sum);
        chk("slot_cout", int'(bus.out_cout), exp_q[0].cout);
        chk("slot_id",   int'(bus.out_id),   exp_q[0].id);
      end
    end
  endtask

  // One clock cycle: entered and left at posedge+1
  task automatic do_cycle(input logic [NREQ-1:0] rq, input logic [4*NREQ-1:0] a,
                          input logic [4*NREQ-1:0] b, input logic rdy);
    int   w;
    int   av;
    int   bv;
    res_t r;
    logic [NREQ-1:0] eg;
    check_state();
    bus.req       = rq;
    bus.a_flat    = a;
    bus.b_flat    = b;
    bus.out_ready = rdy;
    #1;
    w  = (!m_valid || rdy) ? pick(rq, m_ptr) : -1;
    eg = (w >= 0) ? NREQ'(1 << w) : '0;
    chk("gnt", int'(bus.gnt), int'(eg));
    if (w >= 0) begin
      av     = int'((a >> (4 * w)) & 16'hF);
      bv     = int'((b >> (4 * w)) & 16'hF);
      r.sum  = (av + bv) % 16;
      r.cout = (av + bv) / 16;
      r.id   = w;
      exp_q.push_back(r);
      m_ptr   = (w + 1) % NREQ;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed result is popped and compared mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("mon_sum",  int'(bus.out_sum),  e.sum);
          chk("mon_cout", int'(bus.out_cout), e.cout);
          chk("mon_id",   int'(bus.out_id),   e.id);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.a_flat    = '0;
    bus.b_flat    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.req = 4'b1111;
    #1;
    chk("rst_gnt",       int'(bus.gnt),       0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum",   int'(bus.out_sum),   0);
    chk("rst_out_cout",  int'(bus.out_cout),  0);
    chk("rst_out_id",    int'(bus.out_id),    0);
    bus.req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request: 3+4
    do_cycle(4'b0001, 16'h0003, 16'h0004, 1'b1);
    chk("single_sum", int'(bus.out_sum), 7);
    // Wrap-around: 15+1 and 9+9
    do_cycle(4'b0010, 16'h00F0, 16'h0010, 1'b1);
    chk("wrap_sum",  int'(bus.out_sum),  0);
    chk("wrap_cout", int'(bus.out_cout), 1);
    do_cycle(4'b0010, 16'h0090, 16'h0090, 1'b1);
    chk("wrap2_sum", int'(bus.out_sum), 2);

    // Fairness: all requesting for 8 cycles
    for (int c = 0; c < 8; c++) begin
      do_cycle(4'b1111, 16'h4321, 16'h1111, 1'b1);
    end
    do_cycle(4'b0000, '0, '0, 1'b1);

    // Backpressure: load slot, stall 3 cycles, then release
    do_cycle(4'b0001, 16'h0005, 16'h0006, 1'b0);
    for (int c = 0; c < 3; c++) begin
      do_cycle(4'b0110, 16'h0720, 16'h0130, 1'b0);
    end
    do_cycle(4'b0110, 16'h0720, 16'h0130, 1'b1);
    chk("bp_new_id", int'(bus.out_id), 1);

    // Withdraw/skip: ptr to 2, requester 2 withdraws while stalled
    do_cycle(4'b0010, 16'h0020, 16'h0020, 1'b1);
    do_cycle(4'b0101, 16'h0301, 16'h0102, 1'b0);
    do_cycle(4'b0001, 16'h0001, 16'h0002, 1'b1);
    chk("skip_id", int'(bus.out_id), 0);
    do_cycle(4'b0011, 16'h0054, 16'h0011, 1'b1);
    chk("skip_ptr_id", int'(bus.out_id), 1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      do_cycle(NREQ'($urandom), 16'($urandom), 16'($urandom),
               ($urandom_range(0, 3) != 0));
    end

    // Async reset mid-operation with a result pending
    do_cycle(4'b0100, 16'h0A00, 16'h0300, 1'b0);
    check_state();
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(bus.out_valid), 0);
    chk("async_gnt",       int'(bus.gnt),       0);
    m_valid = 1'b0;
    m_ptr   = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_cycle(4'b1000, 16'h8000, 16'h9000, 1'b1);
    chk("post_rst_id",   int'(bus.out_id),   3);
    chk("post_rst_cout", int'(bus.out_cout), 1);
    do_cycle(4'b0000, '0, '0, 1'b1);
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
